multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle ARM control decoder.
- Drives a multicycle ARM datapath with one shared memory: Moore FSM, architectural NZCV register, full ARM condition evaluation, split NZ/CV flag write, and a parametrised ALU-control width.
- Sits between the instruction register fields and the datapath muxes and enables.

Parameters:
- ALU_CTRL_W, 2, ALUControl width. 2 gives ADD=00, SUB=01, AND=10, ORR=11. 3 also gives EOR=100.
- FLAG_W, 4, flag vector width {N,Z,C,V}. Fixed at 4; exposed for package reuse.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cond  in  4  Instr[31:28].
- op  in  2  Instr[27:26].
- funct  in  6  Instr[25:20]: I, cmd[3:0], S (or L for memory ops).
- rd  in  4  Instr[15:12].
- alu_flags  in  FLAG_W  {N,Z,C,V} from ALU, current cycle.
- PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA  out  1 each  datapath enables/selects.
- ALUSrcB  out  2  00=reg, 01=ext imm, 10=const 4.
- ResultSrc  out  2  00=ALUOut reg, 01=mem data reg, 10=ALU direct.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- ImmSrc, RegSrc  out  2 each  same encodings as existing decoder.
- flags_q  out  FLAG_W  architectural NZCV.
- state_q  out  4  current FSM state (debug).

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Reset (rst_n=0 at edge): state_q=FETCH, flags_q=0000. While rst_n=0, PCWrite/IRWrite/MemWrite/RegWrite are forced 0. Reset mid-instruction discards it; no partial writes after the reset edge.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. Next state is always DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8); ImmSrc/RegSrc decoded from op. CondEx is computed from cond and flags_q:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never.
- From DECODE:
  - CondEx=0 -> FETCH. No writes, flags held.
  - op=01 -> MEMADR.
  - op=00 with I=0 -> EXECR; with I=1 -> EXECI.
  - op=10 -> BRANCH.
  - op=11 -> FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next is MEMREAD if L=1, else MEMWRITE.
- MEMREAD: AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01. Asserts RegWrite, or PCWrite instead when rd=15. Next is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
- EXECR/EXECI: ALUSrcA=0; ALUSrcB is 00 (EXECR) or 01 (EXECI). ALUControl comes from cmd:
  - 0100 ADD, 0010 SUB, 1010 CMP (SUB), 0000 AND, 1000 TST (AND), 1100 ORR.
  - 0001 EOR only if ALU_CTRL_W>=3.
  - Otherwise unsupported: ADD, with no writeback and no flags.
- Flag write, at the EXEC* edge when S=1 (forced for CMP/TST):
  - Arithmetic ops load all of NZCV from alu_flags.
  - Logic ops load N,Z only; C,V hold.
- Next state after EXEC* is ALUWB, except CMP/TST/unsupported, which go to FETCH.
- ALUWB: ResultSrc=00. RegWrite=1, or PCWrite=1 instead when rd=15. Next is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, RegSrc[0]=1, ResultSrc=10, PCWrite=1 -> FETCH.
- Latency: DP 4 cycles, CMP/TST 3, LDR 5, STR 4, B 3, failed condition 2.
- Flags written by instruction k are visible to instruction k+1's DECODE.

Optional Feature:
- Macro: MCU_BRANCH_LINK_EN.
- Defined: adds output LinkWrite (1 bit). BRANCH with funct[4]=1 (BL) asserts RegWrite=1 and LinkWrite=1, writing R14 with PC+4 in the same cycle as PCWrite.
- Undefined: no LinkWrite port; funct[4] is ignored in BRANCH.

Decomposition:
- Package mcu_pkg: state_t enum, op codes, cond codes, cmd codes, ALU-control constants, flag bit indices.
- One sub-module: cond_unit, combinational (cond, flags_q -> CondEx).
- FSM and flag register stay in the top.

Test Plan:
- Reset: hold rst_n=0 3 cycles mid-LDR -> state_q=FETCH, flags_q=0000, no MemWrite/RegWrite pulses.
- SUBS with alu_flags=0110 -> FETCH,DECODE,EXECR,ALUWB sequence; flags_q=0110 at cycle 4; RegWrite only in ALUWB.
- ANDS with flags_q=0011, alu_flags=1100 -> flags_q=1111 (C,V held).
- BEQ with Z=0 -> 2 cycles, no PCWrite in cycle 2. BEQ with Z=1 -> BRANCH with PCWrite=1, 3 cycles total.
- GT/LE sweep: all 16 flag combinations × cond 1100/1101/1111 -> CondEx matches the equations; 1111 never executes.
- LDR with rd=15 -> MEMWB asserts PCWrite=1, RegWrite=0. STR -> MemWrite=1 in exactly one cycle.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multicycle ARM control unit:
// FSM states, instruction field codes, ALU-control values and NZCV bit positions.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_ORR = 3;
    localparam int ALU_EOR = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit.sv
// Combinational ARM condition evaluator: cond field and architectural NZCV
// in, CondEx out. Code 1111 never executes.
module cond_unit
    import mcu_pkg::*;
#(
    parameter int FLAG_W = 4
)
(
    input  logic [3:0]        i_cond,
    input  logic [FLAG_W-1:0] i_flags,
    output logic              o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !w_c || w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = !w_z && (w_n == w_v);
            COND_LE: o_cond_ex = w_z || (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM and NZCV register for a multicycle ARM datapath with one
// shared memory. Define MCU_BRANCH_LINK_EN to add the BL link-register write.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W = 2,
    parameter int FLAG_W     = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [FLAG_W-1:0]     alu_flags,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  AdrSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [FLAG_W-1:0]     flags_q,
`ifdef MCU_BRANCH_LINK_EN
    output logic                  LinkWrite,
`endif
    output logic [3:0]            state_q
);

    localparam logic [ALU_CTRL_W-1:0] AC_ADD = ALU_CTRL_W'(ALU_ADD);
    localparam logic [ALU_CTRL_W-1:0] AC_SUB = ALU_CTRL_W'(ALU_SUB);
    localparam logic [ALU_CTRL_W-1:0] AC_AND = ALU_CTRL_W'(ALU_AND);
    localparam logic [ALU_CTRL_W-1:0] AC_ORR = ALU_CTRL_W'(ALU_ORR);
    localparam logic [ALU_CTRL_W-1:0] AC_EOR = ALU_CTRL_W'(ALU_EOR);

    state_t              r_state;
    logic [FLAG_W-1:0]   r_flags;
    logic                w_cond_ex;
    logic [3:0]          w_cmd;
    logic                w_supported;
    logic                w_arith;
    logic                w_compare;
    logic                w_flag_wr;
    logic [ALU_CTRL_W-1:0] w_alu_ctrl;

    assign w_cmd = funct[4:1];

    cond_unit #(.FLAG_W(FLAG_W)) u_cond_unit (
        .i_cond    (cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // Data-processing command decode; unsupported commands run as a harmless ADD.
    always_comb begin
        w_supported = 1'b1;
        w_arith     = 1'b0;
        w_alu_ctrl  = AC_ADD;
        case (w_cmd)
            CMD_ADD: begin w_arith = 1'b1; w_alu_ctrl = AC_ADD; end
            CMD_SUB: begin w_arith = 1'b1; w_alu_ctrl = AC_SUB; end
            CMD_CMP: begin w_arith = 1'b1; w_alu_ctrl = AC_SUB; end
            CMD_AND: w_alu_ctrl = AC_AND;
            CMD_TST: w_alu_ctrl = AC_AND;
            CMD_ORR: w_alu_ctrl = AC_ORR;
            CMD_EOR: begin
                if (ALU_CTRL_W >= 3) w_alu_ctrl = AC_EOR;
                else                 w_supported = 1'b0;
            end
            default: w_supported = 1'b0;
        endcase
    end

    assign w_compare = (w_cmd == CMD_CMP) || (w_cmd == CMD_TST);
    assign w_flag_wr = w_supported && (funct[0] || w_compare);

    // State register and NZCV; logic ops leave C and V untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_flags <= '0;
        end else begin
            case (r_state)
                S_FETCH:   r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_cond_ex)           r_state <= S_FETCH;
                    else if (op == OP_MEM)    r_state <= S_MEMADR;
                    else if (op == OP_DP)     r_state <= funct[5] ? S_EXECI : S_EXECR;
                    else if (op == OP_BR)     r_state <= S_BRANCH;
                    else                      r_state <= S_FETCH;
                end
                S_MEMADR:  r_state <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    r_state <= (w_supported && !w_compare) ? S_ALUWB : S_FETCH;
                    if (w_flag_wr) begin
                        r_flags[FLAG_N] <= alu_flags[FLAG_N];
                        r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
                        if (w_arith) begin
                            r_flags[FLAG_C] <= alu_flags[FLAG_C];
                            r_flags[FLAG_V] <= alu_flags[FLAG_V];
                        end
                    end
                end
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; write enables are held off while reset is asserted.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = AC_ADD;
        ImmSrc     = op;
        RegSrc     = {op == OP_MEM, op == OP_BR};
`ifdef MCU_BRANCH_LINK_EN
        LinkWrite  = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                if (rd == 4'hF) PCWrite  = 1'b1;
                else            RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR:    ALUControl = w_alu_ctrl;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_ctrl;
            end
            S_ALUWB: begin
                if (rd == 4'hF) PCWrite  = 1'b1;
                else            RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                RegSrc[0] = 1'b1;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
`ifdef MCU_BRANCH_LINK_EN
                if (funct[4]) begin
                    RegWrite  = 1'b1;
                    LinkWrite = 1'b1;
                end
`endif
            end
            default: ;
        endcase
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
`ifdef MCU_BRANCH_LINK_EN
            LinkWrite = 1'b0;
`endif
        end
    end

    assign flags_q = r_flags;
    assign state_q = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction table driven
// through a per-cycle scoreboard, a reset-mid-LDR sequence and a condition sweep.
module tb_multicycle_control_unit;

    localparam int ALU_W = 2;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  aflags;
        logic [3:0]  cycles;
        logic [19:0] seq;
        logic [3:0]  expFlags;
        logic [2:0]  expAlu;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] wr;
        logic [3:0] fl;
        logic [2:0] alu;
        logic       chkAlu;
        logic [1:0] op;
    } cyc_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       cond;
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [3:0]       rd;
    logic [3:0]       alu_flags;
    logic             PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0]       ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [ALU_W-1:0] ALUControl;
    logic [3:0]       flags_q;
    logic [3:0]       state_q;
`ifdef MCU_BRANCH_LINK_EN
    logic             LinkWrite;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mflags;
    cyc_t       sb[$];
    vec_t       tbl[17];

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(ALU_W), .FLAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (cond),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .alu_flags  (alu_flags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .flags_q    (flags_q),
`ifdef MCU_BRANCH_LINK_EN
        .LinkWrite  (LinkWrite),
`endif
        .state_q    (state_q)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkVec(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                   input logic [3:0] r, input logic [3:0] af, input logic [3:0] cyc,
                                   input logic [19:0] s, input logic [3:0] ef, input logic [2:0] alu);
        vec_t v;
        v.cond = c; v.op = o; v.funct = f; v.rd = r; v.aflags = af;
        v.cycles = cyc; v.seq = s; v.expFlags = ef; v.expAlu = alu;
        return v;
    endfunction

    // Required write strobes {PCWrite, IRWrite, MemWrite, RegWrite} per state.
    function automatic logic [3:0] expWrites(input logic [3:0] st, input logic [3:0] r, input logic link);
        logic [3:0] w;
        w = 4'b0000;
        case (st)
            4'd0: w = 4'b1100;
            4'd4, 4'd8: w = (r == 4'd15) ? 4'b1000 : 4'b0001;
            4'd5: w = 4'b0010;
`ifdef MCU_BRANCH_LINK_EN
            4'd9: w = link ? 4'b1001 : 4'b1000;
`else
            4'd9: w = 4'b1000;
`endif
            default: w = 4'b0000;
        endcase
        if (link && st == 4'd15) w = 4'b1111;
        return w;
    endfunction

    function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkCycle(input cyc_t e);
        checkOutput("state", 8'(state_q), 8'(e.st));
        checkOutput("writes", 8'({PCWrite, IRWrite, MemWrite, RegWrite}), 8'(e.wr));
        checkOutput("flags", 8'(flags_q), 8'(e.fl));
        if (e.chkAlu) checkOutput("alucontrol", 8'(ALUControl), 8'(e.alu));
        case (e.st)
            4'd0: begin
                checkOutput("fetch_srcA_srcB_res_adr", 8'({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}), 8'b0_1_10_10_0);
                checkOutput("fetch_alu", 8'(ALUControl), 8'd0);
            end
            4'd1: begin
                checkOutput("decode_srcA_srcB_res", 8'({ALUSrcA, ALUSrcB, ResultSrc}), 8'b1_10_10);
                checkOutput("decode_immsrc", 8'(ImmSrc), 8'(e.op));
            end
            4'd2: checkOutput("memadr_srcA_srcB_alu", 8'({ALUSrcA, ALUSrcB, 3'(ALUControl)}), 8'b0_01_000);
            4'd3: checkOutput("memread_adr", 8'(AdrSrc), 8'd1);
            4'd4: checkOutput("memwb_res", 8'(ResultSrc), 8'b01);
            4'd5: checkOutput("memwrite_adr", 8'(AdrSrc), 8'd1);
            4'd6: checkOutput("execr_srcA_srcB", 8'({ALUSrcA, ALUSrcB}), 8'b0_00);
            4'd7: checkOutput("execi_srcA_srcB", 8'({ALUSrcA, ALUSrcB}), 8'b0_01);
            4'd8: checkOutput("aluwb_res", 8'(ResultSrc), 8'b00);
            4'd9: checkOutput("branch_srcA_srcB_res_imm_rs0",
                              8'({ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc[0]}), 8'b0_01_10_10_1);
            default: ;
        endcase
    endtask

    // Drive one instruction at a falling edge, queue its expected cycles, then drain.
    task automatic applyStimulus(input vec_t v);
        cyc_t       e;
        logic [3:0] f;
        logic [3:0] s;
        cond = v.cond; op = v.op; funct = v.funct; rd = v.rd; alu_flags = v.aflags;
        f = mflags;
        for (int c = 0; c < int'(v.cycles); c++) begin
            s = v.seq[19-4*c -: 4];
            e.st     = s;
            e.wr     = expWrites(s, v.rd, (v.op == 2'b10) && v.funct[4]);
            e.fl     = f;
            e.alu    = v.expAlu;
            e.chkAlu = (s == 4'd6) || (s == 4'd7);
            e.op     = v.op;
            sb.push_back(e);
            if (s == 4'd6 || s == 4'd7) f = v.expFlags;
        end
        mflags = v.expFlags;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            #1;
            checkCycle(e);
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ex;
        tbl[0]  = mkVec(4'hE, 2'b00, 6'b0_0010_1, 4'd1,  4'b0110, 4'd4, 20'h01680, 4'b0110, 3'd1);
        tbl[1]  = mkVec(4'hE, 2'b00, 6'b1_0100_1, 4'd2,  4'b0011, 4'd4, 20'h01780, 4'b0011, 3'd0);
        tbl[2]  = mkVec(4'hE, 2'b00, 6'b0_0000_1, 4'd3,  4'b1100, 4'd4, 20'h01680, 4'b1111, 3'd2);
        tbl[3]  = mkVec(4'hE, 2'b00, 6'b0_1010_0, 4'd0,  4'b0110, 4'd3, 20'h01600, 4'b0110, 3'd1);
        tbl[4]  = mkVec(4'h0, 2'b10, 6'b10_0000,  4'd0,  4'b0000, 4'd3, 20'h01900, 4'b0110, 3'd0);
        tbl[5]  = mkVec(4'h1, 2'b10, 6'b10_0000,  4'd0,  4'b0000, 4'd2, 20'h01000, 4'b0110, 3'd0);
        tbl[6]  = mkVec(4'hE, 2'b00, 6'b0_1000_0, 4'd0,  4'b0001, 4'd3, 20'h01600, 4'b0010, 3'd2);
        tbl[7]  = mkVec(4'h0, 2'b10, 6'b10_0000,  4'd0,  4'b0000, 4'd2, 20'h01000, 4'b0010, 3'd0);
        tbl[8]  = mkVec(4'hE, 2'b01, 6'b01_1001,  4'd15, 4'b0000, 4'd5, 20'h01234, 4'b0010, 3'd0);
        tbl[9]  = mkVec(4'hE, 2'b01, 6'b01_1001,  4'd3,  4'b0000, 4'd5, 20'h01234, 4'b0010, 3'd0);
        tbl[10] = mkVec(4'hE, 2'b01, 6'b01_1000,  4'd3,  4'b0000, 4'd4, 20'h01250, 4'b0010, 3'd0);
        tbl[11] = mkVec(4'hE, 2'b00, 6'b0_0111_1, 4'd4,  4'b1111, 4'd3, 20'h01600, 4'b0010, 3'd0);
        tbl[12] = mkVec(4'hE, 2'b00, 6'b0_0001_1, 4'd4,  4'b1000, 4'd3, 20'h01600, 4'b0010, 3'd0);
        tbl[13] = mkVec(4'hE, 2'b00, 6'b0_1100_1, 4'd5,  4'b1001, 4'd4, 20'h01680, 4'b1010, 3'd3);
        tbl[14] = mkVec(4'hF, 2'b00, 6'b0_0100_0, 4'd6,  4'b0000, 4'd2, 20'h01000, 4'b1010, 3'd0);
        tbl[15] = mkVec(4'hE, 2'b00, 6'b0_0100_0, 4'd15, 4'b1111, 4'd4, 20'h01680, 4'b1010, 3'd0);
        tbl[16] = mkVec(4'hE, 2'b11, 6'b00_0000,  4'd0,  4'b0000, 4'd2, 20'h01000, 4'b1010, 3'd0);

        rst_n = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
        mflags = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_state", 8'(state_q), 8'd0);
        checkOutput("reset_flags", 8'(flags_q), 8'd0);
        checkOutput("reset_writes", 8'({PCWrite, IRWrite, MemWrite, RegWrite}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) applyStimulus(tbl[i]);

        // Reset while an LDR sits in MEMWB: writeback must be suppressed.
        cond = 4'hE; op = 2'b01; funct = 6'b01_1001; rd = 4'd3; alu_flags = 4'd0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("ldr_at_memwb", 8'(state_q), 8'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_forces_writes_off", 8'({PCWrite, IRWrite, MemWrite, RegWrite}), 8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("midreset_state", 8'(state_q), 8'd0);
            checkOutput("midreset_flags", 8'(flags_q), 8'd0);
            checkOutput("midreset_writes", 8'({PCWrite, IRWrite, MemWrite, RegWrite}), 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mflags = 4'b0000;
        applyStimulus(tbl[0]);

        // Every condition code against every NZCV value, flags preset by ADDS.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                applyStimulus(mkVec(4'hE, 2'b00, 6'b0_0100_1, 4'd1, 4'(f), 4'd4, 20'h01680, 4'(f), 3'd0));
                ex = condModel(4'(c), 4'(f));
                applyStimulus(mkVec(4'(c), 2'b00, 6'b0_0100_0, 4'd1, 4'(~f), ex ? 4'd4 : 4'd2,
                                    ex ? 20'h01680 : 20'h01000, 4'(f), 3'd0));
            end
        end

        #1;
        checkOutput("final_flags", 8'(flags_q), 8'(mflags));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
